// File: rtl/pll_apb_cfg_master.sv
// pll_apb_cfg_master
//  APB initiator driving the PLL dynamic-reconfiguration port. Single-beat commands
//  from the clock-control logic become APB SETUP/ACCESS transfers. A response pulse
//  returns the read data, or an error when the responder does not answer within
//  TIMEOUT_CYC ACCESS cycles.
//
//  Optional build macro: PLL_DPS_STEP_EN
//   When defined, the block gains dynamic-phase-shift stepping ports. The PLL dps_clk
//   is tied to the APB clock, so everything stays in one clock domain. A step request
//   is accepted only in IDLE when no APB command is offered in the same cycle. Each
//   step is a one-cycle dps_en pulse followed by a wait for dps_done. That wait is
//   bounded by the same timeout counter as the APB path.
//   When the macro is undefined, only the APB path exists.
module pll_apb_cfg_master #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_apb_clk,
    input  logic              i_apb_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_apb_sel,
    output logic              o_apb_en,
    output logic              o_apb_write,
    output logic [ADDR_W-1:0] o_apb_addr,
    output logic [DATA_W-1:0] o_apb_wdata,
    input  logic [DATA_W-1:0] i_apb_rdata,
    input  logic              i_apb_ready
`ifdef PLL_DPS_STEP_EN
    ,
    input  logic              i_dps_req,
    input  logic              i_dps_dir_in,
    input  logic [7:0]        i_dps_steps,
    input  logic              i_dps_done,
    output logic              o_dps_busy,
    output logic              o_dps_en,
    output logic              o_dps_dir
`endif
);

    // The timeout counter is sized for the largest legal TIMEOUT_CYC (65535).
    localparam int          CNT_W    = 16;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_DPS_PULSE = 3'd3,
        ST_DPS_WAIT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // The APB request fields are captured on accept. They stay frozen until the
    // next accept, so they hold their last value in IDLE.
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_write_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [DATA_W-1:0]   w_wdata_next;

    // Counts ACCESS (or step-wait) cycles spent without a handshake.
    logic [CNT_W-1:0]    r_tmo_cnt;
    logic [CNT_W-1:0]    w_tmo_cnt_next;

    // The response is registered. The data and error outputs are zero unless valid is high.
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                w_rsp_valid_next;
    logic                w_rsp_err_next;
    logic [DATA_W-1:0]   w_rsp_rdata_next;

`ifdef PLL_DPS_STEP_EN
    logic                r_dps_dir;
    logic [7:0]          r_dps_left;
    logic                w_dps_dir_next;
    logic [7:0]          w_dps_left_next;
`endif

    // State register and all datapath registers; reset returns to an idle, empty bus.
    always_ff @(posedge i_apb_clk) begin
        if (!i_apb_rst_n) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_tmo_cnt   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef PLL_DPS_STEP_EN
            r_dps_dir   <= 1'b0;
            r_dps_left  <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_write     <= w_write_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_tmo_cnt   <= w_tmo_cnt_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_err   <= w_rsp_err_next;
            r_rsp_rdata <= w_rsp_rdata_next;
`ifdef PLL_DPS_STEP_EN
            r_dps_dir   <= w_dps_dir_next;
            r_dps_left  <= w_dps_left_next;
`endif
        end
    end

    // Next-state and next-datapath decode; the response defaults to an empty (all-zero) pulse.
    always_comb begin
        w_state_next     = r_state;
        w_write_next     = r_write;
        w_addr_next      = r_addr;
        w_wdata_next     = r_wdata;
        w_tmo_cnt_next   = r_tmo_cnt;
        w_rsp_valid_next = 1'b0;
        w_rsp_err_next   = 1'b0;
        w_rsp_rdata_next = '0;
`ifdef PLL_DPS_STEP_EN
        w_dps_dir_next   = r_dps_dir;
        w_dps_left_next  = r_dps_left;
`endif

        case (r_state)
            ST_IDLE: begin
                w_tmo_cnt_next = '0;
                // An APB command wins over a step request offered in the same cycle.
                if (i_cmd_valid) begin
                    w_write_next = i_cmd_write;
                    w_addr_next  = i_cmd_addr;
                    w_wdata_next = i_cmd_wdata;
                    w_state_next = ST_SETUP;
                end
`ifdef PLL_DPS_STEP_EN
                else if (i_dps_req) begin
                    w_dps_dir_next  = i_dps_dir_in;
                    w_dps_left_next = i_dps_steps;
                    // A request for zero steps has nothing to do, so it responds at once.
                    if (i_dps_steps == 8'd0) begin
                        w_rsp_valid_next = 1'b1;
                    end else begin
                        w_state_next = ST_DPS_PULSE;
                    end
                end
`endif
            end

            ST_SETUP: begin
                w_tmo_cnt_next = '0;
                w_state_next   = ST_ACCESS;
            end

            ST_ACCESS: begin
                // If PREADY arrives on the terminal-count cycle, the transfer completes normally.
                if (i_apb_ready) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_rdata_next = r_write ? '0 : i_apb_rdata;
                    w_tmo_cnt_next   = '0;
                    w_state_next     = ST_IDLE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = 1'b1;
                    w_tmo_cnt_next   = '0;
                    w_state_next     = ST_IDLE;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + 1'b1;
                end
            end

`ifdef PLL_DPS_STEP_EN
            ST_DPS_PULSE: begin
                w_tmo_cnt_next = '0;
                w_state_next   = ST_DPS_WAIT;
            end

            ST_DPS_WAIT: begin
                if (i_dps_done) begin
                    w_tmo_cnt_next = '0;
                    if (r_dps_left == 8'd1) begin
                        w_dps_left_next  = '0;
                        w_rsp_valid_next = 1'b1;
                        w_state_next     = ST_IDLE;
                    end else begin
                        w_dps_left_next = r_dps_left - 8'd1;
                        w_state_next    = ST_DPS_PULSE;
                    end
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo_cnt_next   = '0;
                    w_dps_left_next  = '0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = 1'b1;
                    w_state_next     = ST_IDLE;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + 1'b1;
                end
            end
`endif

            default: begin
                w_tmo_cnt_next = '0;
                w_state_next   = ST_IDLE;
            end
        endcase
    end

    // Bus strobes decode straight from the registered state, so they are glitch-free.
    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_apb_sel   = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign o_apb_en    = (r_state == ST_ACCESS);
    assign o_apb_write = r_write;
    assign o_apb_addr  = r_addr;
    assign o_apb_wdata = r_wdata;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_rdata = r_rsp_rdata;

`ifdef PLL_DPS_STEP_EN
    assign o_dps_busy = (r_state == ST_DPS_PULSE) || (r_state == ST_DPS_WAIT);
    assign o_dps_en   = (r_state == ST_DPS_PULSE);
    assign o_dps_dir  = r_dps_dir;
`endif

endmodule

// File: tb/tb_pll_apb_cfg_master.sv
// tb_pll_apb_cfg_master
//  Bench for the APB configuration master in its default (APB-only) build, with
//  TIMEOUT_CYC = 8. A responder process answers ACCESS cycles after a configured
//  number of wait states and drives random PREADY noise outside ACCESS. Table
//  vectors and random commands are each compared with a latency/response model.
//  Hand-written sequences cover reset, mid-transfer reset and back-to-back commands.
module tb_pll_apb_cfg_master;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          i_cmd_write = 1'b0;
    logic [AW-1:0] i_cmd_addr = '0;
    logic [DW-1:0] i_cmd_wdata = '0;
    logic [DW-1:0] i_apb_rdata = '0;
    logic          i_apb_ready = 1'b0;
    logic          o_cmd_ready;
    logic          o_rsp_valid;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_err;
    logic          o_apb_sel;
    logic          o_apb_en;
    logic          o_apb_write;
    logic [AW-1:0] o_apb_addr;
    logic [DW-1:0] o_apb_wdata;

    int            n_checks = 0;
    int            n_fail = 0;

    // Responder configuration: the number of wait cycles before PREADY, and the read data to return.
    int            cfg_wait = 0;
    logic [DW-1:0] cfg_rdata = '0;
    int            acc_cnt = 0;

    always #5 clk = ~clk;

    pll_apb_cfg_master #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_apb_clk   (clk),
        .i_apb_rst_n (rst_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_write (i_cmd_write),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_wdata (i_cmd_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_apb_sel   (o_apb_sel),
        .o_apb_en    (o_apb_en),
        .o_apb_write (o_apb_write),
        .o_apb_addr  (o_apb_addr),
        .o_apb_wdata (o_apb_wdata),
        .i_apb_rdata (i_apb_rdata),
        .i_apb_ready (i_apb_ready)
    );

    // APB responder: counts ACCESS cycles and raises PREADY after cfg_wait of them. Outside ACCESS it drives random noise.
    always @(negedge clk) begin
        if (o_apb_sel && o_apb_en) begin
            i_apb_ready = (acc_cnt == cfg_wait);
            i_apb_rdata = (acc_cnt == cfg_wait) ? cfg_rdata : DW'($urandom);
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            i_apb_ready = 1'($urandom_range(0, 1));
            i_apb_rdata = DW'($urandom);
        end
    end

    // Hard stop in case the bench itself stalls.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the response follows from the wait count alone.
    function automatic int model_lat(input int wt);
        return (wt < TO) ? 3 + wt : 2 + TO;
    endfunction

    // Issues one command from an IDLE negedge and follows it to the response.
    // It returns on the negedge after the response pulse.
    task automatic do_txn(input string nm, input logic wr, input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd, input int wt, input logic [DW-1:0] rd,
                          input logic e_err, input logic [DW-1:0] e_rdata, input int e_lat);
        int lat;
        bit got;
        cfg_wait = wt;
        cfg_rdata = rd;
        chk({nm, " cmd_ready_idle"}, 32'(o_cmd_ready), 1);
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_cmd_addr  = ad;
        i_cmd_wdata = wd;
        @(negedge clk);
        // The command inputs change after accept; the bus must keep the captured values.
        i_cmd_valid = 1'b0;
        i_cmd_write = ~wr;
        i_cmd_addr  = ~ad;
        i_cmd_wdata = ~wd;
        chk({nm, " setup_sel"}, 32'(o_apb_sel), 1);
        chk({nm, " setup_en"}, 32'(o_apb_en), 0);
        chk({nm, " setup_cmd_ready"}, 32'(o_cmd_ready), 0);
        lat = 1;
        got = 1'b0;
        while (!got && lat < e_lat + 4) begin
            chk({nm, " addr_stable"}, 32'(o_apb_addr), 32'(ad));
            chk({nm, " write_stable"}, 32'(o_apb_write), 32'(wr));
            chk({nm, " wdata_stable"}, 32'(o_apb_wdata), 32'(wd));
            @(negedge clk);
            lat++;
            if (o_rsp_valid) begin
                got = 1'b1;
            end else begin
                chk({nm, " access_sel"}, 32'(o_apb_sel), 1);
                chk({nm, " access_en"}, 32'(o_apb_en), 1);
                chk({nm, " rsp_rdata_quiet"}, 32'(o_rsp_rdata), 0);
                chk({nm, " rsp_err_quiet"}, 32'(o_rsp_err), 0);
            end
        end
        chk({nm, " rsp_seen"}, 32'(got), 1);
        chk({nm, " latency"}, 32'(lat), 32'(e_lat));
        chk({nm, " rsp_err"}, 32'(o_rsp_err), 32'(e_err));
        chk({nm, " rsp_rdata"}, 32'(o_rsp_rdata), 32'(e_rdata));
        chk({nm, " rsp_cmd_ready"}, 32'(o_cmd_ready), 1);
        chk({nm, " rsp_sel_low"}, 32'(o_apb_sel), 0);
        $display("txn %s wr=%0b addr=%h wdata=%h wait=%0d lat=%0d err=%0b rdata=%h",
                 nm, wr, ad, wd, wt, lat, o_rsp_err, o_rsp_rdata);
        @(negedge clk);
        chk({nm, " rsp_one_cycle"}, 32'(o_rsp_valid), 0);
        chk({nm, " rdata_zero_after"}, 32'(o_rsp_rdata), 0);
        chk({nm, " addr_hold_idle"}, 32'(o_apb_addr), 32'(ad));
    endtask

    typedef struct {
        string         nm;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            wt;
        logic [DW-1:0] rd;
        logic          e_err;
        logic [DW-1:0] e_rdata;
        int            e_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // Each expected value follows the timing T+3+wait, or T+2+TO on timeout, for TO = 8.
        vecs[0] = '{"wr_zero_wait",   1'b1, 5'h03, 16'hA5C3,  0, 16'hBEEF, 1'b0, 16'h0000,  3};
        vecs[1] = '{"rd_three_wait",  1'b0, 5'h1F, 16'h0000,  3, 16'h1234, 1'b0, 16'h1234,  6};
        vecs[2] = '{"rd_terminal",    1'b0, 5'h0A, 16'h5555,  7, 16'hCAFE, 1'b0, 16'hCAFE, 10};
        vecs[3] = '{"rd_timeout",     1'b0, 5'h11, 16'h0000, 50, 16'hDEAD, 1'b1, 16'h0000, 10};
        vecs[4] = '{"wr_timeout",     1'b1, 5'h00, 16'hFFFF,  8, 16'h7777, 1'b1, 16'h0000, 10};
        vecs[5] = '{"rd_one_wait",    1'b0, 5'h00, 16'h0000,  1, 16'h0001, 1'b0, 16'h0001,  4};

        // Reset state: a command offered during reset is ignored.
        rst_n = 1'b0;
        i_cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst cmd_ready", 32'(o_cmd_ready), 1);
        chk("rst rsp_valid", 32'(o_rsp_valid), 0);
        chk("rst rsp_err", 32'(o_rsp_err), 0);
        chk("rst rsp_rdata", 32'(o_rsp_rdata), 0);
        chk("rst sel", 32'(o_apb_sel), 0);
        chk("rst en", 32'(o_apb_en), 0);
        chk("rst write", 32'(o_apb_write), 0);
        chk("rst addr", 32'(o_apb_addr), 0);
        chk("rst wdata", 32'(o_apb_wdata), 0);
        i_cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst sel", 32'(o_apb_sel), 0);

        // Table-driven vectors.
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].nm, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wt,
                   vecs[i].rd, vecs[i].e_err, vecs[i].e_rdata, vecs[i].e_lat);
        end

        // Random commands checked against the model.
        for (int i = 0; i < 30; i++) begin
            logic          wr;
            logic [AW-1:0] ad;
            logic [DW-1:0] wd;
            logic [DW-1:0] rd;
            int            wt;
            wr = 1'($urandom_range(0, 1));
            ad = AW'($urandom);
            wd = DW'($urandom);
            rd = DW'($urandom);
            wt = $urandom_range(0, 10);
            do_txn($sformatf("rand%0d", i), wr, ad, wd, wt, rd,
                   (wt >= TO), (!wr && wt < TO) ? rd : '0, model_lat(wt));
        end

        // Back-to-back: cmd_valid held high across two commands.
        cfg_wait = 0;
        cfg_rdata = 16'h5A5A;
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b1;
        i_cmd_addr  = 5'h03;
        i_cmd_wdata = 16'h1111;
        @(negedge clk);
        i_cmd_write = 1'b0;
        i_cmd_addr  = 5'h1F;
        i_cmd_wdata = 16'h2222;
        chk("b2b setup_addr_a", 32'(o_apb_addr), 32'h03);
        @(negedge clk);
        chk("b2b access_addr_a", 32'(o_apb_addr), 32'h03);
        chk("b2b access_en_a", 32'(o_apb_en), 1);
        @(negedge clk);
        chk("b2b rsp_a", 32'(o_rsp_valid), 1);
        chk("b2b rsp_a_rdata", 32'(o_rsp_rdata), 0);
        chk("b2b ready_on_rsp", 32'(o_cmd_ready), 1);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        chk("b2b rsp_a_once", 32'(o_rsp_valid), 0);
        chk("b2b setup_sel_b", 32'(o_apb_sel), 1);
        chk("b2b setup_en_b", 32'(o_apb_en), 0);
        chk("b2b setup_addr_b", 32'(o_apb_addr), 32'h1F);
        chk("b2b setup_write_b", 32'(o_apb_write), 0);
        @(negedge clk);
        chk("b2b access_en_b", 32'(o_apb_en), 1);
        @(negedge clk);
        chk("b2b rsp_b", 32'(o_rsp_valid), 1);
        chk("b2b rsp_b_rdata", 32'(o_rsp_rdata), 32'h5A5A);
        $display("txn b2b two commands, second rdata=%h", o_rsp_rdata);
        @(negedge clk);

        // Reset in the middle of ACCESS aborts the transfer with no response.
        cfg_wait = 100;
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b0;
        i_cmd_addr  = 5'h15;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mrst in_access", 32'(o_apb_en), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst sel_drop", 32'(o_apb_sel), 0);
        chk("mrst en_drop", 32'(o_apb_en), 0);
        chk("mrst no_rsp", 32'(o_rsp_valid), 0);
        chk("mrst addr_clr", 32'(o_apb_addr), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mrst quiet_rsp", 32'(o_rsp_valid), 0);
            chk("mrst quiet_sel", 32'(o_apb_sel), 0);
        end
        chk("mrst cmd_ready", 32'(o_cmd_ready), 1);
        $display("txn mid_access_reset aborted");
        do_txn("after_reset", 1'b0, 5'h07, 16'h0000, 2, 16'h0F0F, 1'b0, 16'h0F0F, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
